// File: rtl/line_packer.sv
// Packs BEAT_WIDTH-wide input beats into one BEATS-wide line with a per-beat valid mask.
// pin_last closes a line early, and flush drops any partial or held line.
module line_packer #(
    parameter int BEAT_WIDTH = 16,
    parameter int BEATS      = 4,
    localparam int IW        = (BEATS > 1) ? $clog2(BEATS) : 1,
    localparam int LW        = BEATS * BEAT_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  pin_valid,
    output logic                  pin_ready,
    input  logic [BEAT_WIDTH-1:0] pin_data,
    input  logic                  pin_last,
    output logic                  pout_valid,
    input  logic                  pout_ready,
    output logic [LW-1:0]         pout_data,
    output logic [BEATS-1:0]      pout_mask,
    output logic                  dbg_state
);

    // Handshake: a transfer happens on a rising clock edge when valid & ready are both high.
    // pout_valid never looks at pout_ready. Once raised, it stays high with stable data and
    // mask until the line is accepted or flushed.

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [LW-1:0]      data_q, data_d;
    logic [BEATS-1:0]   mask_q, mask_d;
    logic               flush_eff;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= COLLECT;
            idx_q   <= '0;
            data_q  <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        mask_d  = mask_q;
        if (flush) begin
            state_d = COLLECT;
            idx_d   = '0;
            data_d  = '0;
            mask_d  = '0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (pin_valid) begin
                        data_d[int'(idx_q)*BEAT_WIDTH +: BEAT_WIDTH] = pin_data;
                        mask_d[idx_q] = 1'b1;
                        if (pin_last || idx_q == IW'(BEATS - 1)) begin
                            state_d = HOLD;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (pout_ready) begin
                        // Line leaves this cycle; a simultaneous beat starts the next line in slot 0.
                        state_d = COLLECT;
                        idx_d   = '0;
                        data_d  = '0;
                        mask_d  = '0;
                        if (pin_valid) begin
                            data_d[BEAT_WIDTH-1:0] = pin_data;
                            mask_d[0] = 1'b1;
                            if (pin_last) begin
                                state_d = HOLD;
                            end else begin
                                idx_d = IW'(1);
                            end
                        end
                    end
                end
                default: begin
                    state_d = COLLECT;
                end
            endcase
        end
    end

    // Flush only masks the handshakes outside reset, so pin_ready reads 1 while in reset.
    always_comb begin
        flush_eff  = flush & reset;
        pin_ready  = 1'b0;
        pout_valid = 1'b0;
        case (state_q)
            COLLECT: pin_ready  = ~flush_eff;
            HOLD: begin
                pin_ready  = pout_ready & ~flush_eff;
                pout_valid = ~flush_eff;
            end
            default: pin_ready = 1'b0;
        endcase
        pout_data = data_q;
        pout_mask = mask_q;
        dbg_state = state_q;
    end

endmodule
